// File: rtl/lut_ctrl_pkg.sv
// Shared state encoding, default geometry and the init-value rule for the
// lookup-table sequencer/arbiter.
package lut_ctrl_pkg;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_SERVE = 1'b1
    } lut_state_t;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MULT       = 2;
    localparam int DEF_ADD        = 2;

    // Evaluated at 32-bit int width; callers truncate to the entry width.
    function automatic int init_value(input int mult, input int add, input int idx);
        return mult * (idx + add);
    endfunction

endpackage

// File: rtl/lut_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module lut_rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid0,
    input  logic       valid1,
    input  logic       enable,
    output logic [1:0] grant
);

    logic       r_last_grant;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        if (enable) begin
            if (valid0 && valid1) begin
                w_grant = r_last_grant ? 2'b01 : 2'b10;
            end else begin
                w_grant = {valid1, valid0};
            end
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (|w_grant) begin
            r_last_grant <= w_grant[1];
        end
    end

    assign grant = w_grant;

endmodule

// File: rtl/lut_init_arbiter.sv
// Fills a lookup table with MULT*(i+ADD) one entry per cycle, then shares its
// single read port between two requesters with a one-cycle read latency.
module lut_init_arbiter
    import lut_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MULT       = DEF_MULT,
    parameter int ADD        = DEF_ADD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  init_done,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output lut_state_t            dbg_state,
    output logic [ADDR_WIDTH-1:0] dbg_idx
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    lut_state_t            r_state;
    lut_state_t            w_state_next;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [ADDR_WIDTH-1:0] w_idx_next;
    logic [DATA_WIDTH-1:0] r_table [DEPTH];
    logic [1:0]            w_grant;
    logic                  w_arb_en;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic [DATA_WIDTH-1:0] r_rsp0_data;
    logic [DATA_WIDTH-1:0] r_rsp1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // init_req always restarts from entry 0, including on the final write.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            S_INIT: begin
                if (init_req) begin
                    w_idx_next = '0;
                end else if (r_idx == LAST_IDX) begin
                    w_state_next = S_SERVE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + ADDR_WIDTH'(1);
                end
            end
            S_SERVE: begin
                if (init_req) begin
                    w_state_next = S_INIT;
                    w_idx_next   = '0;
                end
            end
            default: begin
                w_state_next = S_INIT;
                w_idx_next   = '0;
            end
        endcase
    end

    // Storage is deliberately not reset; contents are meaningful only in S_SERVE.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_table[r_idx] <= DATA_WIDTH'(init_value(MULT, ADD, int'(r_idx)));
        end
    end

    assign w_arb_en = (r_state == S_SERVE) && !init_req;

    lut_rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .enable (w_arb_en),
        .grant  (w_grant)
    );

    // Responses already owed still land even if init_req arrives next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_data  <= '0;
            r_rsp1_data  <= '0;
        end else begin
            r_rsp0_valid <= w_grant[0];
            r_rsp1_valid <= w_grant[1];
            if (w_grant[0]) begin
                r_rsp0_data <= r_table[req0_addr];
            end
            if (w_grant[1]) begin
                r_rsp1_data <= r_table[req1_addr];
            end
        end
    end

    assign init_busy  = (r_state == S_INIT);
    assign init_done  = (r_state == S_SERVE);
    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_data  = r_rsp0_data;
    assign rsp1_data  = r_rsp1_data;
    assign dbg_state  = r_state;
    assign dbg_idx    = r_idx;

endmodule

// File: tb/tb_lut_init_arbiter.sv
// Self-checking bench for lut_init_arbiter: default instance plus a MULT=20
// instance driven in lockstep, both checked every cycle against a cycle model.
module tb_lut_init_arbiter;
    import lut_ctrl_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          init_req;
    logic          req0_valid;
    logic          req1_valid;
    logic [AW-1:0] req0_addr;
    logic [AW-1:0] req1_addr;

    logic          busy_a, done_a, rdy0_a, rdy1_a, rv0_a, rv1_a;
    logic [DW-1:0] rd0_a, rd1_a;
    lut_state_t    st_a;
    logic [AW-1:0] idx_a;
    logic          busy_b, done_b, rdy0_b, rdy1_b, rv0_b, rv1_b;
    logic [DW-1:0] rd0_b, rd1_b;
    lut_state_t    st_b;
    logic [AW-1:0] idx_b;

    lut_init_arbiter u_dut_a (
        .clk(clk), .rst(rst), .init_req(init_req),
        .init_busy(busy_a), .init_done(done_a),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(rdy0_a),
        .rsp0_valid(rv0_a), .rsp0_data(rd0_a),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(rdy1_a),
        .rsp1_valid(rv1_a), .rsp1_data(rd1_a),
        .dbg_state(st_a), .dbg_idx(idx_a)
    );

    lut_init_arbiter #(.MULT(20), .ADD(2)) u_dut_b (
        .clk(clk), .rst(rst), .init_req(init_req),
        .init_busy(busy_b), .init_done(done_b),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(rdy0_b),
        .rsp0_valid(rv0_b), .rsp0_data(rd0_b),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(rdy1_b),
        .rsp1_valid(rv1_b), .rsp1_data(rd1_b),
        .dbg_state(st_b), .dbg_idx(idx_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: table contents from the init formula, plus init progress,
    // last winner, and the response each requester should currently show.
    int tab_a [DEPTH];
    int tab_b [DEPTH];
    bit m_done;
    int m_cnt;
    int m_last;
    bit m_rv [2];
    int m_da [2];
    int m_db [2];
    bit g0, g1;
    bit act [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_done = 1'b0;
        m_cnt  = 0;
        m_last = 1;
        for (int r = 0; r < 2; r++) begin
            m_rv[r] = 1'b0;
            m_da[r] = 0;
            m_db[r] = 0;
        end
    endtask

    // Called at a falling edge with inputs already driven; checks, advances the
    // model across the next rising edge, returns at the following falling edge.
    task automatic tick();
        bit serve;
        #1;
        serve = m_done && !init_req;
        g0 = 1'b0;
        g1 = 1'b0;
        if (serve) begin
            if (req0_valid && req1_valid) begin
                g0 = (m_last == 1);
                g1 = !g0;
            end else begin
                g0 = req0_valid;
                g1 = req1_valid;
            end
        end
        chk("req0_ready_a", rdy0_a, g0);
        chk("req1_ready_a", rdy1_a, g1);
        chk("req0_ready_b", rdy0_b, g0);
        chk("req1_ready_b", rdy1_b, g1);
        chk("init_busy", busy_a, !m_done);
        chk("init_done", done_a, m_done);
        chk("init_done_b", done_b, m_done);
        chk("rsp0_valid_a", rv0_a, m_rv[0]);
        chk("rsp1_valid_a", rv1_a, m_rv[1]);
        chk("rsp0_valid_b", rv0_b, m_rv[0]);
        chk("rsp1_valid_b", rv1_b, m_rv[1]);
        chk("rsp0_data_a", rd0_a, m_da[0]);
        chk("rsp1_data_a", rd1_a, m_da[1]);
        chk("rsp0_data_b", rd0_b, m_db[0]);
        chk("rsp1_data_b", rd1_b, m_db[1]);
        if (!m_done) chk("init_idx", idx_a, m_cnt);
        if (g0) act[0] = 1'b0;
        if (g1) act[1] = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            m_rv[0] = g0;
            m_rv[1] = g1;
            if (g0) begin
                m_da[0] = tab_a[req0_addr];
                m_db[0] = tab_b[req0_addr];
            end
            if (g1) begin
                m_da[1] = tab_a[req1_addr];
                m_db[1] = tab_b[req1_addr];
            end
            if (g0 || g1) m_last = g1 ? 1 : 0;
            if (!m_done) begin
                if (init_req) m_cnt = 0;
                else if (m_cnt == DEPTH - 1) begin
                    m_done = 1'b1;
                    m_cnt  = 0;
                end else m_cnt++;
            end else if (init_req) begin
                m_done = 1'b0;
                m_cnt  = 0;
            end
        end
        @(negedge clk);
    endtask

    // Random requesters that hold valid/addr until granted, occasionally giving up.
    task automatic drive_reqs(input int p_new, input int p_drop);
        if (act[0] && $urandom_range(99) < p_drop) act[0] = 1'b0;
        else if (!act[0] && $urandom_range(99) < p_new) begin
            act[0]    = 1'b1;
            req0_addr = AW'($urandom_range(DEPTH - 1));
        end
        if (act[1] && $urandom_range(99) < p_drop) act[1] = 1'b0;
        else if (!act[1] && $urandom_range(99) < p_new) begin
            act[1]    = 1'b1;
            req1_addr = AW'($urandom_range(DEPTH - 1));
        end
        req0_valid = act[0];
        req1_valid = act[1];
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            tab_a[i] = (2 * (i + 2)) % 256;
            tab_b[i] = (20 * (i + 2)) % 256;
        end
        rst = 1'b1; init_req = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
        act[0] = 1'b0; act[1] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        tick();
        rst = 1'b0;

        // Requester 1 waits through init for entry 5.
        req1_valid = 1'b1; req1_addr = 4'd5; act[1] = 1'b1;
        n = 0;
        while (act[1] && n < 40) begin
            tick();
            n++;
        end
        chk("first_grant_cycle", n, 17);
        chk("rsp1_addr5_valid", rv1_a, 1);
        chk("rsp1_addr5_data", rd1_a, 14);
        req1_valid = 1'b0;

        req0_valid = 1'b1; req0_addr = 4'd0;
        tick();
        req0_valid = 1'b0;
        chk("rsp0_addr0_a", rd0_a, 4);
        chk("rsp0_addr0_b", rd0_b, 40);
        req0_valid = 1'b1; req0_addr = 4'd15;
        tick();
        req0_valid = 1'b0;
        chk("rsp0_addr15_a", rd0_a, 34);
        chk("rsp0_addr15_b", rd0_b, 84);
        tick();

        // Both held valid: strict alternation.
        req0_valid = 1'b1; req0_addr = 4'd3;
        req1_valid = 1'b1; req1_addr = 4'd7;
        repeat (12) tick();

        // init_req right after a req0 grant with both still valid.
        n = 0;
        g0 = 1'b0;
        while (!g0 && n < 4) begin
            tick();
            n++;
        end
        chk("req0_grant_seen", g0, 1);
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        n = 0;
        while (!m_done && n < 40) begin
            tick();
            n++;
        end
        chk("reinit_busy_cycles", n, 16);
        act[0] = 1'b0; act[1] = 1'b0;
        repeat (40) begin
            drive_reqs(60, 5);
            tick();
        end

        // Reset in the middle of init.
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        n = 0;
        while (m_cnt != 7 && n < 40) begin
            tick();
            n++;
        end
        chk("reached_idx7", idx_a, 7);
        rst = 1'b1;
        drive_reqs(80, 0);
        tick();
        rst = 1'b0;
        repeat (30) begin
            drive_reqs(50, 5);
            tick();
        end

        // Long random run with occasional re-initialisation.
        repeat (500) begin
            drive_reqs($urandom_range(90, 20), 5);
            init_req = ($urandom_range(99) == 0);
            tick();
        end
        init_req = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
